ppfifo_wr_arbiter: RTL and testbench
====================================

Name: ppfifo_wr_arbiter

Overview:
Shares the write side of one Ping Pong FIFO between two independent writers, such as pattern sources or packetisers. The block acquires a free downstream buffer and offers it to one writer, granting round-robin among requesters. Each writer sees a standard PPFIFO write interface (rdy/act/size/stb/data). The block sits between the writers and the PPFIFO write port.

Parameters:
DATA_WIDTH, 8, width of write data on all ports
SIZE_WIDTH, 24, width of buffer size and strobe counter

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
i_enable  in  1  allows acquisition of new downstream buffers
i_req  in  2  per-writer request to be granted a buffer
o_grant  out  2  one-hot current owner; 0 when no owner
i_fifo_wr_rdy  in  2  downstream buffer ready flags
o_fifo_wr_act  out  2  downstream buffer activate, one-hot or 0
i_fifo_wr_size  in  SIZE_WIDTH  downstream buffer capacity
o_fifo_wr_stb  out  1  downstream write strobe
o_fifo_wr_data  out  DATA_WIDTH  downstream write data
o_r0_wr_rdy / o_r1_wr_rdy  out  2  per-writer virtual ready
i_r0_wr_act / i_r1_wr_act  in  2  per-writer activate
o_r0_wr_size / o_r1_wr_size  out  SIZE_WIDTH  per-writer size (mirror of i_fifo_wr_size)
i_r0_wr_stb / i_r1_wr_stb  in  1  per-writer strobe
i_r0_wr_data / i_r1_wr_data  in  DATA_WIDTH  per-writer data
o_overflow  out  1  sticky: owner strobed past buffer size

Behaviour:
- Reset: state IDLE, rr pointer = 0, count = 0. All outputs are 0: o_fifo_wr_act, o_fifo_wr_stb, o_fifo_wr_data, o_rN_wr_rdy, o_grant, o_overflow. The o_rN_wr_size outputs are continuous mirrors of i_fifo_wr_size.
- Reset mid-transfer drops o_fifo_wr_act the next cycle. Partial buffer content is the downstream's concern.
- FSM states: IDLE, ACQUIRE, OFFER, BUSY, RELEASE.
- IDLE: if i_enable, i_req != 0 and i_fifo_wr_rdy != 0, register ch = (rdy[0] ? 0 : 1), set o_fifo_wr_act[ch] = 1, go to ACQUIRE. Otherwise hold.
- ACQUIRE (1 cycle): clear count, go to OFFER.
- OFFER, each cycle:
  - Select writer w = rr if i_req[rr], else the other writer if requesting.
  - Drive o_rw_wr_rdy = one-hot(ch); the other writer's rdy = 0.
  - When i_rw_wr_act != 0: set o_grant = one-hot(w), drop o_rw_wr_rdy, go to BUSY.
  - If i_req == 0: rdy = 0 and the downstream buffer stays held; i_enable is not consulted.
  - If both writers raise act in the same cycle, only the offered writer is accepted.
- BUSY: o_fifo_wr_stb / o_fifo_wr_data <= owner's stb/data, registered with 1 cycle latency.
  - Each owner strobe increments count.
  - A strobe while count == i_fifo_wr_size is not forwarded and sets o_overflow, which is cleared only by rst.
  - Non-owner strobes are ignored.
  - When the owner's act returns to 0, go to RELEASE.
- RELEASE (1 cycle):
  - o_fifo_wr_act <= 0, one cycle after the owner's act falls, so the last registered strobe precedes the act drop.
  - o_grant <= 0, rr <= ~w, go to IDLE.
  - Zero-length ownership (act up then down with no strobes) is released normally.
- i_enable low affects only IDLE. Transfers already in progress complete.
- count is SIZE_WIDTH bits and never wraps, because the compare blocks at size.
- The owner never sees rdy again during its own ownership.

Decomposition:
- Package ppfifo_pkg: PPFIFO_SIZE_WIDTH = 24, FSM state enum, channel-select constants.
- One sub-module, ppfifo_rr_select: 2-way round-robin picker. Inputs are req[1:0] and ptr; outputs are sel and valid; purely combinational.
- The FSM, counter and datapath mux stay in ppfifo_wr_arbiter.

Test Plan:
1. Single writer: rdy = 2'b01, size = 4, r0 requests and writes 4 strobes of data 0..3 -> fifo_wr_act = 01, fifo stb/data 0..3 each 1 cycle late, act drops 1 cycle after r0's act drops, overflow = 0.
2. Both writers request continuously, size = 2, rdy toggling 01/10 -> grants alternate r0, r1, r0, r1. Channel is 0 on the first buffer and 1 on the next.
3. Owner strobes 5 times with size = 3 -> exactly 3 fifo strobes, o_overflow = 1 and stays 1 until rst.
4. Non-owner r1 strobes data 0xAA during r0's ownership -> no 0xAA appears on o_fifo_wr_data and count is unaffected.
5. rst asserted in BUSY after 2 strobes -> next cycle all outputs are 0 and state is IDLE. A following request is granted to r0.
6. i_enable = 0 with requests pending and rdy = 11 -> no act asserted. Dropping i_enable mid-BUSY lets the transfer complete and release normally.

Source files
------------

// File: rtl/ppfifo_pkg.sv
// Shared types and constants for the Ping Pong FIFO write arbiter.
package ppfifo_pkg;

  localparam int unsigned PPFIFO_SIZE_WIDTH = 24;

  typedef enum logic [2:0] {
    StIdle,
    StAcquire,
    StOffer,
    StBusy,
    StRelease
  } state_e;

  // Downstream buffer channel selects
  localparam logic CH0 = 1'b0;
  localparam logic CH1 = 1'b1;

  // Two-way one-hot encode of a single select bit
  function automatic logic [1:0] onehot2(input logic sel);
    return sel ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/ppfifo_rr_select.sv
// Two-way round-robin picker: prefers the writer at ptr, else the other one.
module ppfifo_rr_select (
  input  logic [1:0] req,
  input  logic       ptr,
  output logic       sel,
  output logic       valid
);

  // Pick the pointed-to requester first, fall back to the other
  always_comb begin
    valid = |req;
    sel   = ptr;
    if (!req[ptr]) begin
      sel = ~ptr;
    end
  end

endmodule

// File: rtl/ppfifo_wr_arbiter.sv
// Shares one PPFIFO write port between two writers, round-robin per buffer.
module ppfifo_wr_arbiter
  import ppfifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned SIZE_WIDTH = PPFIFO_SIZE_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_enable,
  input  logic [1:0]            i_req,
  output logic [1:0]            o_grant,
  input  logic [1:0]            i_fifo_wr_rdy,
  output logic [1:0]            o_fifo_wr_act,
  input  logic [SIZE_WIDTH-1:0] i_fifo_wr_size,
  output logic                  o_fifo_wr_stb,
  output logic [DATA_WIDTH-1:0] o_fifo_wr_data,
  output logic [1:0]            o_r0_wr_rdy,
  input  logic [1:0]            i_r0_wr_act,
  output logic [SIZE_WIDTH-1:0] o_r0_wr_size,
  input  logic                  i_r0_wr_stb,
  input  logic [DATA_WIDTH-1:0] i_r0_wr_data,
  output logic [1:0]            o_r1_wr_rdy,
  input  logic [1:0]            i_r1_wr_act,
  output logic [SIZE_WIDTH-1:0] o_r1_wr_size,
  input  logic                  i_r1_wr_stb,
  input  logic [DATA_WIDTH-1:0] i_r1_wr_data,
  output logic                  o_overflow
);

  state_e                state_q, state_d;
  logic                  rr_q, rr_d;
  logic                  ch_q, ch_d;
  logic                  owner_q, owner_d;
  logic [1:0]            act_q, act_d;
  logic [1:0]            grant_q, grant_d;
  logic [SIZE_WIDTH-1:0] count_q, count_d;
  logic                  stb_q, stb_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  ovf_q, ovf_d;

  logic                  sel;
  logic                  sel_valid;
  logic [1:0]            offer_act;
  logic [1:0]            owner_act;
  logic                  owner_stb;
  logic [DATA_WIDTH-1:0] owner_data;

  ppfifo_rr_select u_rr_select (
    .req   (i_req),
    .ptr   (rr_q),
    .sel   (sel),
    .valid (sel_valid)
  );

  // Writer-side muxes: the currently offered writer and the current owner
  always_comb begin
    offer_act  = sel ? i_r1_wr_act : i_r0_wr_act;
    owner_act  = owner_q ? i_r1_wr_act : i_r0_wr_act;
    owner_stb  = owner_q ? i_r1_wr_stb : i_r0_wr_stb;
    owner_data = owner_q ? i_r1_wr_data : i_r0_wr_data;
  end

  // Next-state, datapath and virtual-ready generation
  always_comb begin
    state_d     = state_q;
    rr_d        = rr_q;
    ch_d        = ch_q;
    owner_d     = owner_q;
    act_d       = act_q;
    grant_d     = grant_q;
    count_d     = count_q;
    stb_d       = 1'b0;
    data_d      = data_q;
    ovf_d       = ovf_q;
    o_r0_wr_rdy = 2'b00;
    o_r1_wr_rdy = 2'b00;

    case (state_q)
      StIdle: begin
        if (i_enable && (i_req != 2'b00) && (i_fifo_wr_rdy != 2'b00)) begin
          ch_d    = i_fifo_wr_rdy[0] ? CH0 : CH1;
          act_d   = onehot2(ch_d);
          state_d = StAcquire;
        end
      end

      StAcquire: begin
        count_d = '0;
        state_d = StOffer;
      end

      StOffer: begin
        // Buffer stays held even if requests vanish; rdy simply goes quiet.
        // rdy stays up in the accept cycle and falls once BUSY is entered.
        if (sel_valid) begin
          if (sel) begin
            o_r1_wr_rdy = onehot2(ch_q);
          end else begin
            o_r0_wr_rdy = onehot2(ch_q);
          end
          if (offer_act != 2'b00) begin
            grant_d = onehot2(sel);
            owner_d = sel;
            state_d = StBusy;
          end
        end
      end

      StBusy: begin
        if (owner_stb) begin
          if (count_q == i_fifo_wr_size) begin
            ovf_d = 1'b1;
          end else begin
            stb_d   = 1'b1;
            data_d  = owner_data;
            count_d = count_q + SIZE_WIDTH'(1);
          end
        end
        if (owner_act == 2'b00) begin
          state_d = StRelease;
        end
      end

      StRelease: begin
        // Act falls here, after the last registered strobe has gone out
        act_d   = 2'b00;
        grant_d = 2'b00;
        rr_d    = ~owner_q;
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State register with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      rr_q    <= 1'b0;
      ch_q    <= CH0;
      owner_q <= 1'b0;
      act_q   <= 2'b00;
      grant_q <= 2'b00;
      count_q <= '0;
      stb_q   <= 1'b0;
      data_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      ch_q    <= ch_d;
      owner_q <= owner_d;
      act_q   <= act_d;
      grant_q <= grant_d;
      count_q <= count_d;
      stb_q   <= stb_d;
      data_q  <= data_d;
      ovf_q   <= ovf_d;
    end
  end

  assign o_fifo_wr_act  = act_q;
  assign o_grant        = grant_q;
  assign o_fifo_wr_stb  = stb_q;
  assign o_fifo_wr_data = data_q;
  assign o_overflow     = ovf_q;
  assign o_r0_wr_size   = i_fifo_wr_size;
  assign o_r1_wr_size   = i_fifo_wr_size;

endmodule

// File: tb/tb_ppfifo_wr_arbiter.sv
// Scoreboard bench for ppfifo_wr_arbiter: behavioural writers, queued expectations.
module tb_ppfifo_wr_arbiter;

  localparam int DW = 8;
  localparam int SW = 24;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en = 1'b0;
  logic [1:0]    req = 2'b00;
  logic [1:0]    fifo_rdy = 2'b00;
  logic [SW-1:0] fifo_size = SW'(4);
  logic [1:0]    wr_act [2];
  logic          wr_stb [2];
  logic [DW-1:0] wr_data [2];

  logic [1:0]    grant;
  logic [1:0]    fifo_act;
  logic          fifo_stb;
  logic [DW-1:0] fifo_data;
  logic [1:0]    r0_rdy, r1_rdy;
  logic [SW-1:0] r0_size, r1_size;
  logic          overflow;

  int            n_checks = 0;
  int            n_errors = 0;
  logic [DW-1:0] sb [$];
  logic [DW-1:0] exp_data;

  ppfifo_wr_arbiter #(
    .DATA_WIDTH (DW),
    .SIZE_WIDTH (SW)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .i_enable       (en),
    .i_req          (req),
    .o_grant        (grant),
    .i_fifo_wr_rdy  (fifo_rdy),
    .o_fifo_wr_act  (fifo_act),
    .i_fifo_wr_size (fifo_size),
    .o_fifo_wr_stb  (fifo_stb),
    .o_fifo_wr_data (fifo_data),
    .o_r0_wr_rdy    (r0_rdy),
    .i_r0_wr_act    (wr_act[0]),
    .o_r0_wr_size   (r0_size),
    .i_r0_wr_stb    (wr_stb[0]),
    .i_r0_wr_data   (wr_data[0]),
    .o_r1_wr_rdy    (r1_rdy),
    .i_r1_wr_act    (wr_act[1]),
    .o_r1_wr_size   (r1_size),
    .i_r1_wr_stb    (wr_stb[1]),
    .i_r1_wr_data   (wr_data[1]),
    .o_overflow     (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Every downstream strobe must match the next queued expectation
  always @(negedge clk) begin
    if (fifo_stb === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_stb", 32'd1, 32'd0);
      end else begin
        exp_data = sb.pop_front();
        check("fifo_data", 32'(fifo_data), 32'(exp_data));
      end
    end
  end

  // One full ownership: wait for an offer, activate, strobe n times, release
  task automatic serve(input int exp_w, input int exp_ch, input int n, input logic [DW-1:0] base,
                       input bit aa, input bit drop_en);
    int         w;
    int         other;
    logic [1:0] rv;
    bit         seen;
    seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      tick();
      if (r0_rdy != 2'b00 || r1_rdy != 2'b00) seen = 1'b1;
    end
    if (!seen) begin
      check("offer_timeout", 32'd0, 32'd1);
      return;
    end
    w     = (r0_rdy != 2'b00) ? 0 : 1;
    other = 1 - w;
    rv    = (w == 0) ? r0_rdy : r1_rdy;
    check("offer_writer", 32'(w), 32'(exp_w));
    check("offer_rdy", 32'(rv), 32'd1 << exp_ch);
    check("fifo_act_on", 32'(fifo_act), 32'd1 << exp_ch);
    check("other_rdy_low", 32'((w == 0) ? r1_rdy : r0_rdy), 32'd0);
    wr_act[w] = rv;
    tick();
    check("grant", 32'(grant), 32'd1 << w);
    check("owner_rdy_low", 32'((w == 0) ? r0_rdy : r1_rdy), 32'd0);
    if (drop_en) en = 1'b0;
    for (int i = 0; i < n; i++) begin
      wr_stb[w]  = 1'b1;
      wr_data[w] = base + DW'(i);
      if (i < int'(fifo_size)) sb.push_back(base + DW'(i));
      if (aa) begin
        wr_stb[other]  = 1'b1;
        wr_data[other] = 8'hAA;
      end
      tick();
    end
    wr_stb[0] = 1'b0;
    wr_stb[1] = 1'b0;
    wr_act[w] = 2'b00;
    tick();
    check("act_held_in_release", 32'(fifo_act), 32'd1 << exp_ch);
    tick();
    check("act_dropped", 32'(fifo_act), 32'd0);
    check("grant_cleared", 32'(grant), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    bit seen;
    wr_act[0]  = 2'b00;
    wr_act[1]  = 2'b00;
    wr_stb[0]  = 1'b0;
    wr_stb[1]  = 1'b0;
    wr_data[0] = '0;
    wr_data[1] = '0;
    repeat (3) tick();

    // Reset state
    check("rst_act", 32'(fifo_act), 32'd0);
    check("rst_stb", 32'(fifo_stb), 32'd0);
    check("rst_data", 32'(fifo_data), 32'd0);
    check("rst_r0_rdy", 32'(r0_rdy), 32'd0);
    check("rst_r1_rdy", 32'(r1_rdy), 32'd0);
    check("rst_grant", 32'(grant), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("r0_size_mirror", 32'(r0_size), 32'd4);
    check("r1_size_mirror", 32'(r1_size), 32'd4);
    rst = 1'b0;
    en  = 1'b1;

    // Both writers requesting: grants alternate, channel follows rdy
    fifo_size = SW'(2);
    req       = 2'b11;
    for (int k = 0; k < 4; k++) begin
      fifo_rdy = (k % 2 == 0) ? 2'b01 : 2'b10;
      serve(k % 2, k % 2, 2, DW'(8'h10 + 8 * k), 1'b0, 1'b0);
    end
    req = 2'b00;

    // Single writer, four strobes into a size-4 buffer
    fifo_size = SW'(4);
    fifo_rdy  = 2'b01;
    req       = 2'b01;
    serve(0, 0, 4, 8'h00, 1'b0, 1'b0);
    check("no_overflow", 32'(overflow), 32'd0);

    // Five strobes into a size-3 buffer: three forwarded, overflow sticks
    fifo_size = SW'(3);
    serve(0, 0, 5, 8'h20, 1'b0, 1'b0);
    check("overflow_set", 32'(overflow), 32'd1);

    // Non-owner strobes 0xAA alongside a full-size owner transfer
    fifo_size = SW'(4);
    serve(0, 0, 4, 8'h30, 1'b1, 1'b0);
    check("overflow_sticky", 32'(overflow), 32'd1);

    // Reset in BUSY after two strobes
    seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      tick();
      if (r0_rdy != 2'b00) seen = 1'b1;
    end
    check("rst_test_offer", 32'(seen), 32'd1);
    wr_act[0] = r0_rdy;
    tick();
    for (int i = 0; i < 2; i++) begin
      wr_stb[0]  = 1'b1;
      wr_data[0] = DW'(8'h50 + i);
      sb.push_back(DW'(8'h50 + i));
      tick();
    end
    wr_stb[0] = 1'b0;
    rst       = 1'b1;
    tick();
    check("midrst_act", 32'(fifo_act), 32'd0);
    check("midrst_stb", 32'(fifo_stb), 32'd0);
    check("midrst_grant", 32'(grant), 32'd0);
    check("midrst_overflow", 32'(overflow), 32'd0);
    check("midrst_r0_rdy", 32'(r0_rdy), 32'd0);
    rst       = 1'b0;
    wr_act[0] = 2'b00;
    req       = 2'b11;
    serve(0, 0, 1, 8'h60, 1'b0, 1'b0);
    req = 2'b00;

    // Enable low blocks acquisition; dropping it mid-BUSY still completes
    en       = 1'b0;
    fifo_rdy = 2'b11;
    req      = 2'b11;
    repeat (10) tick();
    check("disabled_no_act", 32'(fifo_act), 32'd0);
    check("disabled_no_rdy", 32'({r0_rdy, r1_rdy}), 32'd0);
    en = 1'b1;
    serve(1, 0, 3, 8'h70, 1'b0, 1'b1);
    repeat (5) tick();
    check("disabled_after_release", 32'(fifo_act), 32'd0);
    req = 2'b00;

    repeat (3) tick();
    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
